// File: rtl/sum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_pkg
// Purpose  : Shared widths, state encoding and beat helper for sum_accumulator
// Revision : 1.0  initial release
// ============================================================================
package sum_accumulator_pkg;

    localparam int c_BEAT_W = 5;
    localparam int c_CNT_W  = 4;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // One adder result: carry on top of the four sum bits.
    function automatic logic [c_BEAT_W-1:0] beat_value(input logic carry,
                                                       input logic [3:0] sum);
        return {carry, sum};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_if
// Purpose  : Beat input and block-total output handshakes of sum_accumulator
// Revision : 1.0  initial release
// ============================================================================
interface sum_accumulator_if #(
    parameter int ACC_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_sum;
    logic                 in_carry;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_overflow;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_acc, out_overflow
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_acc, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/sum_accumulator_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder / acc_ripple_adder
// Purpose  : One-bit full adder cell and the WIDTH-bit ripple chain built from it
// Revision : 1.0  initial release
// ============================================================================
module full_adder (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_cin,
    output logic      o_sum,
    output logic      o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module acc_ripple_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder u_fa (
                .i_a    (i_a[gi]),
                .i_b    (i_b[gi]),
                .i_cin  (w_carry[gi]),
                .o_sum  (o_sum[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the top bit is the wrap indication for the accumulator.
    assign o_cout = w_carry[WIDTH];
endmodule
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Purpose  : Sums COUNT adder beats into a block total held on a valid/ready output
// Revision : 1.0  initial release
// ============================================================================
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clear,
    sum_accumulator_if.slave  bus
);
    generate
        if (ACC_WIDTH < c_BEAT_W) begin : g_bad_width
            $error("sum_accumulator: ACC_WIDTH must be at least 5");
        end
        if (COUNT < 1 || COUNT > 15) begin : g_bad_count
            $error("sum_accumulator: COUNT must be in 1..15");
        end
    endgenerate

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [ACC_WIDTH-1:0]   w_beat;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic                   w_cout;
    logic                   w_accept;
    logic                   w_out_fire;
    logic                   w_last;
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic [ACC_WIDTH-1:0]   w_out_acc;
    logic                   w_out_ovf;

    assign w_beat     = ACC_WIDTH'(beat_value(bus.in_carry, bus.in_sum));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && bus.out_ready;
    assign w_last     = (r_cnt == c_CNT_W'(COUNT - 1));

    acc_ripple_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .i_a    (r_acc),
        .i_b    (w_beat),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_accept && w_last) w_state_next = ST_HOLD;
                ST_HOLD:  if (w_out_fire)         w_state_next = ST_ACCUM;
                default:                          w_state_next = ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_acc   = '0;
        w_out_ovf   = 1'b0;
        case (r_state)
            ST_ACCUM: w_in_ready = 1'b1;
            ST_HOLD: begin
                w_out_valid = 1'b1;
                w_out_acc   = r_acc;
                w_out_ovf   = r_ovf;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    // Datapath: clear drops any beat offered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_cout;
            r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end else if (w_out_fire) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_acc      = w_out_acc;
    assign bus.out_overflow = w_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Purpose  : Directed vector bench for three sum_accumulator configurations
// Revision : 1.0  initial release
// ============================================================================
module tb_sum_accumulator;

    typedef struct {
        int        dut;     // 0: 8b/COUNT4, 1: 6b/COUNT4, 2: 8b/COUNT1
        bit        rst;
        bit        clr;
        bit        iv;
        bit [3:0]  sum;
        bit        car;
        bit        ordy;
        bit        e_ir;
        bit        e_ov;
        bit [7:0]  e_acc;
        bit        e_ovf;
        string     name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    sum_accumulator_if #(.ACC_WIDTH(8)) ifa();
    sum_accumulator_if #(.ACC_WIDTH(6)) ifb();
    sum_accumulator_if #(.ACC_WIDTH(8)) ifc();

    sum_accumulator #(.ACC_WIDTH(8), .COUNT(4)) u_dut_a (
        .clk (clk), .rst (rst), .clear (clr_a), .bus (ifa)
    );
    sum_accumulator #(.ACC_WIDTH(6), .COUNT(4)) u_dut_b (
        .clk (clk), .rst (rst), .clear (clr_b), .bus (ifb)
    );
    sum_accumulator #(.ACC_WIDTH(8), .COUNT(1)) u_dut_c (
        .clk (clk), .rst (rst), .clear (clr_c), .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic void add(int dut, bit r, bit clr, bit iv, bit [3:0] sum, bit car,
                                bit ordy, bit eir, bit eov, bit [7:0] eacc, bit eovf,
                                string name);
        vec_t v;
        v.dut = dut; v.rst = r; v.clr = clr; v.iv = iv; v.sum = sum; v.car = car;
        v.ordy = ordy; v.e_ir = eir; v.e_ov = eov; v.e_acc = eacc; v.e_ovf = eovf;
        v.name = name;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, int dut, bit eir, bit eov, bit [7:0] eacc, bit eovf);
        bit       a_ir, a_ov, a_ovf;
        bit [7:0] a_acc;
        case (dut)
            0:       begin a_ir = ifa.in_ready; a_ov = ifa.out_valid; a_acc = ifa.out_acc;       a_ovf = ifa.out_overflow; end
            1:       begin a_ir = ifb.in_ready; a_ov = ifb.out_valid; a_acc = {2'b00, ifb.out_acc}; a_ovf = ifb.out_overflow; end
            default: begin a_ir = ifc.in_ready; a_ov = ifc.out_valid; a_acc = ifc.out_acc;       a_ovf = ifc.out_overflow; end
        endcase
        n_vec++;
        if (a_ir !== eir || a_ov !== eov || a_acc !== eacc || a_ovf !== eovf) begin
            n_err++;
            $display("FAIL %s (dut%0d): got in_ready=%0b out_valid=%0b out_acc=%0d ovf=%0b, expected in_ready=%0b out_valid=%0b out_acc=%0d ovf=%0b",
                     name, dut, a_ir, a_ov, a_acc, a_ovf, eir, eov, eacc, eovf);
        end
    endtask

    task automatic drive(int dut, bit r, bit clr, bit iv, bit [3:0] sum, bit car, bit ordy);
        rst   = r;
        clr_a = (dut == 0) && clr;
        clr_b = (dut == 1) && clr;
        clr_c = (dut == 2) && clr;
        ifa.in_valid = (dut == 0) && iv; ifa.in_sum = sum; ifa.in_carry = car; ifa.out_ready = (dut == 0) && ordy;
        ifb.in_valid = (dut == 1) && iv; ifb.in_sum = sum; ifb.in_carry = car; ifb.out_ready = (dut == 1) && ordy;
        ifc.in_valid = (dut == 2) && iv; ifc.in_sum = sum; ifc.in_carry = car; ifc.out_ready = (dut == 2) && ordy;
    endtask

    initial begin
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // dut r  clr iv sum car ordy | ir ov acc ovf
        // Basic block 3+31+16+5 = 55
        add(0, 0, 0, 1,  3, 0, 0, 1, 0,  0, 0, "reset_state");
        add(0, 0, 0, 1, 15, 1, 0, 1, 0,  0, 0, "basic_b2");
        add(0, 0, 0, 1,  0, 1, 0, 1, 0,  0, 0, "basic_b3");
        add(0, 0, 0, 1,  5, 0, 0, 1, 0,  0, 0, "basic_b4");
        // Backpressure with beats offered and ignored
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 9, 0, 0, 0, 1, 8'h37, 0, "backpressure_hold");
        add(0, 0, 0, 0,  0, 0, 1, 0, 1, 8'h37, 0, "out_handshake");
        add(0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, "in_ready_return");
        // Gaps then clear with a beat offered: 14 discarded
        add(0, 0, 0, 1,  7, 0, 0, 1, 0,  0, 0, "gap_b1");
        add(0, 0, 0, 1,  7, 0, 0, 1, 0,  0, 0, "gap_b2");
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "gap_idle");
        add(0, 0, 1, 1, 15, 1, 0, 1, 0,  0, 0, "clear_drop");
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, "post_clear_beat");
        add(0, 0, 0, 0,  0, 0, 1, 0, 1,  4, 0, "post_clear_total");
        add(0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, "post_clear_idle");
        // Gapped beats of 10, then clear while holding 40
        add(0, 0, 0, 1, 10, 0, 0, 1, 0,  0, 0, "gapped_b1");
        add(0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, "gapped_idle");
        add(0, 0, 0, 1, 10, 0, 0, 1, 0,  0, 0, "gapped_b2");
        add(0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, "gapped_idle");
        add(0, 0, 0, 1, 10, 0, 0, 1, 0,  0, 0, "gapped_b3");
        add(0, 0, 0, 1, 10, 0, 0, 1, 0,  0, 0, "gapped_b4");
        add(0, 0, 1, 0,  0, 0, 0, 0, 1, 40, 0, "clear_in_hold");
        add(0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0, "held_discarded");
        add(0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, "held_discarded2");
        // ACC_WIDTH=6: 4 x 31 = 124 -> 60 with overflow
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 1, 15, 1, 0, 1, 0, 0, 0, "ovf_beat");
        add(1, 0, 0, 0,  0, 0, 0, 0, 1, 60, 1, "ovf_hold");
        add(1, 0, 0, 0,  0, 0, 1, 0, 1, 60, 1, "ovf_handshake");
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, "ovf_next_beat");
        add(1, 0, 0, 0,  0, 0, 1, 0, 1,  4, 0, "ovf_cleared");
        add(1, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, "ovf_idle");
        // COUNT=1 back-to-back: totals 31, 0, 9
        add(2, 0, 0, 1, 15, 1, 1, 1, 0,  0, 0, "c1_beat31");
        add(2, 0, 0, 1,  0, 0, 1, 0, 1, 31, 0, "c1_total31");
        add(2, 0, 0, 1,  0, 0, 1, 1, 0,  0, 0, "c1_beat0");
        add(2, 0, 0, 1,  9, 0, 1, 0, 1,  0, 0, "c1_total0");
        add(2, 0, 0, 1,  9, 0, 1, 1, 0,  0, 0, "c1_beat9");
        add(2, 0, 0, 0,  0, 0, 1, 0, 1,  9, 0, "c1_total9");
        add(2, 0, 0, 0,  0, 0, 1, 1, 0,  0, 0, "c1_idle");

        repeat (2) @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            chk(vq[i].name, vq[i].dut, vq[i].e_ir, vq[i].e_ov, vq[i].e_acc, vq[i].e_ovf);
            drive(vq[i].dut, vq[i].rst, vq[i].clr, vq[i].iv, vq[i].sum, vq[i].car, vq[i].ordy);
        end

        // Reset while holding 55: total is lost and never reappears
        @(negedge clk); drive(0, 0, 0, 1,  3, 0, 0);
        @(negedge clk); drive(0, 0, 0, 1, 15, 1, 0);
        @(negedge clk); drive(0, 0, 0, 1,  0, 1, 0);
        @(negedge clk); drive(0, 0, 0, 1,  5, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0,  0, 0, 0);
        for (int k = 0; k < 10 && !ifa.out_valid; k++) @(negedge clk);
        chk("rst_hold_pre", 0, 0, 1, 8'h37, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_hold_post", 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_stale", 0, 1, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
